// File: rtl/ahb_split_pkg.sv
// Shared types for the AHB SPLIT scheduler: bus encodings and FSM state enums.
package ahb_split_pkg;

    localparam int MID_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [1:0] {FREE, OWNED, RESERVED} res_state_t;

    typedef enum logic [1:0] {RESP_IDLE, ERR1, ERR2} resp_state_t;

endpackage

// File: rtl/ahb_split_ctrl_if.sv
// AHB slave-side signal bundle for the SPLIT scheduler, including the HSPLITx wake vector.
interface ahb_split_ctrl_if
    import ahb_split_pkg::*;
#(
    parameter int NUM_MASTERS = 16
);
    logic                   HSEL;
    htrans_t                HTRANS;
    logic                   HREADY;
    logic [MID_W-1:0]       HMASTER;
    logic                   HMASTLOCK;
    logic                   HREADYOUT;
    hresp_t                 HRESP;
    logic [NUM_MASTERS-1:0] HSPLITx;

    modport slave (
        input  HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK,
        output HREADYOUT, HRESP, HSPLITx
    );

    modport master (
        output HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK,
        input  HREADYOUT, HRESP, HSPLITx
    );
endinterface

// File: rtl/split_rr_pick.sv
// Combinational round-robin picker: first pending master strictly after the last-served one.
module split_rr_pick #(
    parameter int N     = 16,
    parameter int PTR_W = 4
) (
    input  logic [N-1:0]     pend,
    input  logic [PTR_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic             valid
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PTR_W'((int'(last) + i) % N);
            if (!valid && pend[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ahb_split_ctrl.sv
// SPLIT scheduler sharing one back-end resource among AHB masters.
// Define AHB_SPLIT_STATS_EN to add saturating split/retry/timeout counters.
module ahb_split_ctrl
    import ahb_split_pkg::*;
#(
    parameter int NUM_MASTERS = 16,
    parameter int RESERVE_TO  = 16,
    parameter int CNT_W       = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_split_ctrl_if.slave  bus,
    output logic             res_start,
    input  logic             res_done,
    output logic [MID_W-1:0] owner,
    output logic             owner_vld
`ifdef AHB_SPLIT_STATS_EN
    ,
    output logic [CNT_W-1:0] split_cnt,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] timeout_cnt
`endif
);
    // state    | meaning
    // FREE     | resource idle, first accept takes it
    // OWNED    | owner holds the resource until res_done
    // RESERVED | woken master (owner reg) has first claim until the timer expires
    localparam int TMR_W = $clog2(RESERVE_TO + 1);

    if (RESERVE_TO < 2 || CNT_W < 1) begin : g_bad_param
        $error("ahb_split_ctrl: RESERVE_TO must be >= 2 and CNT_W >= 1");
    end

    res_state_t             res_st;
    resp_state_t            resp_st;
    logic [NUM_MASTERS-1:0] pending;
    logic [MID_W-1:0]       last_ptr;
    logic [TMR_W-1:0]       timer;

    logic                   acc, timeout, rel, is_cur, absorbed, hit, gvalid;
    logic [NUM_MASTERS-1:0] req_oh, pend_eff, grant, pend1;
    logic [MID_W-1:0]       grant_id, id1;
    res_state_t             st1;

    assign acc      = bus.HSEL && (bus.HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ})
                      && bus.HREADY && (resp_st == RESP_IDLE);
    assign req_oh   = NUM_MASTERS'(1) << bus.HMASTER;
    assign timeout  = (res_st == RESERVED) && (timer == TMR_W'(1));
    assign rel      = ((res_st == OWNED) && res_done) || timeout;
    assign is_cur   = (res_st != FREE) && (bus.HMASTER == owner);
    // A non-owner split landing on a release joins the very pick it triggers.
    assign absorbed = rel && acc && !is_cur && !bus.HMASTLOCK;
    assign pend_eff = pending | (absorbed ? req_oh : '0);

    split_rr_pick #(.N(NUM_MASTERS), .PTR_W(MID_W)) u_pick (
        .pend  (pend_eff),
        .last  (last_ptr),
        .grant (grant),
        .valid (gvalid)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) grant_id = MID_W'(i);
        end
    end

    // Post-release view: accepts are judged against the state after any release.
    assign st1   = rel ? (gvalid ? RESERVED : FREE) : res_st;
    assign id1   = (rel && gvalid) ? grant_id : owner;
    assign pend1 = (rel && gvalid) ? (pend_eff & ~grant) : pend_eff;
    assign hit   = (st1 != FREE) && (bus.HMASTER == id1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            res_st        <= FREE;
            resp_st       <= RESP_IDLE;
            pending       <= '0;
            last_ptr      <= MID_W'(NUM_MASTERS - 1);
            timer         <= '0;
            owner         <= '0;
            owner_vld     <= 1'b0;
            res_start     <= 1'b0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= HRESP_OKAY;
            bus.HSPLITx   <= '0;
`ifdef AHB_SPLIT_STATS_EN
            split_cnt     <= '0;
            retry_cnt     <= '0;
            timeout_cnt   <= '0;
`endif
        end else begin
            res_start   <= 1'b0;
            bus.HSPLITx <= '0;
            res_st      <= st1;
            owner       <= id1;
            owner_vld   <= (st1 == OWNED);
            pending     <= pend1;

            if (rel && gvalid) begin
                bus.HSPLITx <= grant;
                last_ptr    <= grant_id;
                timer       <= TMR_W'(RESERVE_TO);
            end else if (res_st == RESERVED) begin
                timer <= timer - TMR_W'(1);
            end

            case (resp_st)
                ERR1: begin
                    bus.HREADYOUT <= 1'b1;
                    resp_st       <= ERR2;
                end
                ERR2: begin
                    bus.HRESP <= HRESP_OKAY;
                    resp_st   <= RESP_IDLE;
                end
                default: bus.HRESP <= HRESP_OKAY;
            endcase

            if (absorbed) begin
                bus.HRESP     <= HRESP_SPLIT;
                bus.HREADYOUT <= 1'b0;
                resp_st       <= ERR1;
            end else if (acc) begin
                if (st1 == FREE || (st1 == RESERVED && hit)) begin
                    res_st    <= OWNED;
                    owner     <= bus.HMASTER;
                    owner_vld <= 1'b1;
                    res_start <= 1'b1;
                end else if (!hit) begin
                    bus.HREADYOUT <= 1'b0;
                    resp_st       <= ERR1;
                    if (bus.HMASTLOCK) begin
                        bus.HRESP <= HRESP_RETRY;
                    end else begin
                        bus.HRESP <= HRESP_SPLIT;
                        pending   <= pend1 | req_oh;
                    end
                end
            end

`ifdef AHB_SPLIT_STATS_EN
            if ((absorbed || (acc && st1 != FREE && !hit && !bus.HMASTLOCK)) && split_cnt != '1)
                split_cnt <= split_cnt + CNT_W'(1);
            if (!absorbed && acc && st1 != FREE && !hit && bus.HMASTLOCK && retry_cnt != '1)
                retry_cnt <= retry_cnt + CNT_W'(1);
            if (timeout && timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + CNT_W'(1);
`endif
        end
    end
endmodule
